pwm_dt_gen: RTL and testbench

- Downstream stage of the PI current controller: turns the signed 32-bit PI output into one complementary PWM leg with dead-time insertion.
- Duty commands are clamped and double-buffered, so a new duty only takes effect at a PWM period boundary.
- Sits between pi_ctrl_top and the gate-driver pins.

---
 rtl/pwm_dt_gen.sv | 198 +++++++++++++++++++
 tb/tb_pwm_dt_gen.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_dt_gen.sv
// Complementary PWM leg with clamped, period-double-buffered duty and dead-time insertion.
// Gate outputs come from a Moore FSM so H and L can never be high together.
module pwm_dt_gen #(
    parameter int CNT_W  = 16,
    parameter int PERIOD = 1000,
    parameter int DEAD   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      duty_i,
    input  logic             duty_vld_i,
    output logic             pwm_h_o,
    output logic             pwm_l_o,
    output logic             period_start_o,
    output logic             duty_load_o,
    output logic [CNT_W-1:0] duty_act_o
);

    typedef enum logic [2:0] {
        ST_SAFE  = 3'd0,
        ST_LOW   = 3'd1,
        ST_DT_LH = 3'd2,
        ST_HIGH  = 3'd3,
        ST_DT_HL = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]  CNT_PERIOD = CNT_W'(PERIOD);
    localparam logic signed [31:0] PERIOD_S  = 32'(PERIOD);
    localparam logic [7:0]        DEAD_LAST  = 8'(DEAD - 1);

    // Saturate the signed PI output into the legal duty range 0..PERIOD.
    function automatic logic [CNT_W-1:0] clamp_duty(input logic signed [31:0] d);
        logic [CNT_W-1:0] r;
        if (d < 32'sd0) begin
            r = CNT_ZERO;
        end else if (d > PERIOD_S) begin
            r = CNT_PERIOD;
        end else begin
            r = d[CNT_W-1:0];
        end
        return r;
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
    logic [CNT_W-1:0] duty_act_q, duty_act_d;
    logic [CNT_W-1:0] duty_cl_s;
    logic             raw_q, raw_d;
    logic             duty_load_q, duty_load_d;
    logic             period_start_q;
    state_t           state_q;
    logic [7:0]       dead_q;
    logic             pwm_h_q, pwm_l_q;

    // Next-state for carrier, shadow/active duty and raw compare.
    always_comb begin
        cnt_d       = cnt_q;
        duty_sh_d   = duty_sh_q;
        duty_act_d  = duty_act_q;
        duty_load_d = 1'b0;
        duty_cl_s   = clamp_duty($signed(duty_i));
        if (cnt_q == CNT_LAST) begin
            cnt_d = CNT_ZERO;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
        if (duty_vld_i) begin
            duty_sh_d = duty_cl_s;
        end else begin
            duty_sh_d = duty_sh_q;
        end
        // A strobe on the boundary edge bypasses the shadow straight into the active duty.
        if (cnt_q == CNT_LAST) begin
            duty_load_d = 1'b1;
            if (duty_vld_i) begin
                duty_act_d = duty_cl_s;
            end else begin
                duty_act_d = duty_sh_q;
            end
        end else begin
            duty_load_d = 1'b0;
            duty_act_d  = duty_act_q;
        end
        raw_d = (cnt_q < duty_act_q);
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q          <= CNT_ZERO;
            duty_sh_q      <= CNT_ZERO;
            duty_act_q     <= CNT_ZERO;
            raw_q          <= 1'b0;
            duty_load_q    <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            duty_sh_q      <= duty_sh_d;
            duty_act_q     <= duty_act_d;
            raw_q          <= raw_d;
            duty_load_q    <= duty_load_d;
            period_start_q <= (cnt_d == CNT_ZERO);
        end
    end

    // Dead-time FSM; raw_q is checked before expiry so short pulses abort cleanly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_SAFE;
            dead_q  <= 8'd0;
            pwm_h_q <= 1'b0;
            pwm_l_q <= 1'b0;
        end else begin
            case (state_q)
                ST_SAFE: begin
                    if (dead_q == DEAD_LAST) begin
                        dead_q  <= 8'd0;
                        state_q <= raw_q ? ST_HIGH : ST_LOW;
                        pwm_h_q <= raw_q;
                        pwm_l_q <= ~raw_q;
                    end else begin
                        dead_q  <= dead_q + 8'd1;
                        pwm_h_q <= 1'b0;
                        pwm_l_q <= 1'b0;
                    end
                end
                ST_LOW: begin
                    if (raw_q) begin
                        state_q <= ST_DT_LH;
                        dead_q  <= 8'd0;
                        pwm_h_q <= 1'b0;
                        pwm_l_q <= 1'b0;
                    end else begin
                        pwm_h_q <= 1'b0;
                        pwm_l_q <= 1'b1;
                    end
                end
                ST_DT_LH: begin
                    if (!raw_q) begin
                        state_q <= ST_LOW;
                        pwm_h_q <= 1'b0;
                        pwm_l_q <= 1'b1;
                    end else if (dead_q == DEAD_LAST) begin
                        state_q <= ST_HIGH;
                        pwm_h_q <= 1'b1;
                        pwm_l_q <= 1'b0;
                    end else begin
                        dead_q  <= dead_q + 8'd1;
                        pwm_h_q <= 1'b0;
                        pwm_l_q <= 1'b0;
                    end
                end
                ST_HIGH: begin
                    if (!raw_q) begin
                        state_q <= ST_DT_HL;
                        dead_q  <= 8'd0;
                        pwm_h_q <= 1'b0;
                        pwm_l_q <= 1'b0;
                    end else begin
                        pwm_h_q <= 1'b1;
                        pwm_l_q <= 1'b0;
                    end
                end
                ST_DT_HL: begin
                    if (raw_q) begin
                        state_q <= ST_HIGH;
                        pwm_h_q <= 1'b1;
                        pwm_l_q <= 1'b0;
                    end else if (dead_q == DEAD_LAST) begin
                        state_q <= ST_LOW;
                        pwm_h_q <= 1'b0;
                        pwm_l_q <= 1'b1;
                    end else begin
                        dead_q  <= dead_q + 8'd1;
                        pwm_h_q <= 1'b0;
                        pwm_l_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_SAFE;
                    dead_q  <= 8'd0;
                    pwm_h_q <= 1'b0;
                    pwm_l_q <= 1'b0;
                end
            endcase
        end
    end

    assign pwm_h_o        = pwm_h_q;
    assign pwm_l_o        = pwm_l_q;
    assign period_start_o = period_start_q;
    assign duty_load_o    = duty_load_q;
    assign duty_act_o     = duty_act_q;

endmodule

// File: tb/tb_pwm_dt_gen.sv
// Randomized bench for pwm_dt_gen: gates are predicted from raw-run lengths and the last
// committed side rather than from a state machine.
module tb_pwm_dt_gen;

    localparam int CNT_W  = 16;
    localparam int PERIOD = 100;
    localparam int DEAD   = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [31:0]      duty_i = 32'd0;
    logic             duty_vld_i = 1'b0;
    logic             pwm_h_o, pwm_l_o, period_start_o, duty_load_o;
    logic [CNT_W-1:0] duty_act_o;

    int n_chk = 0;
    int n_fail = 0;

    pwm_dt_gen #(.CNT_W(CNT_W), .PERIOD(PERIOD), .DEAD(DEAD)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .duty_i         (duty_i),
        .duty_vld_i     (duty_vld_i),
        .pwm_h_o        (pwm_h_o),
        .pwm_l_o        (pwm_l_o),
        .period_start_o (period_start_o),
        .duty_load_o    (duty_load_o),
        .duty_act_o     (duty_act_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference state: current cycle's carrier, duties, raw compare and predicted outputs.
    int m_cnt, m_sh, m_act, m_since, m_run, m_side;
    bit m_raw, m_h, m_l, m_ps, m_load;
    bit m_valid = 1'b0;

    function automatic int clamp(input int d);
        if (d < 0) return 0;
        else if (d > PERIOD) return PERIOD;
        else return d;
    endfunction

    initial begin
        int n, cl;
        bit nr;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_cnt = 0; m_sh = 0; m_act = 0; m_raw = 1'b0; m_run = 1;
                m_h = 1'b0; m_l = 1'b0; m_ps = 1'b0; m_load = 1'b0;
                m_side = 0; m_since = 0; m_valid = 1'b1;
            end else if (m_valid) begin
                n = m_since + 1;
                // Gate on only after DEAD+1 cycles of stable raw, unless returning to the side already held.
                if (n < DEAD) begin
                    m_h = 1'b0; m_l = 1'b0;
                end else if (n == DEAD) begin
                    m_h = m_raw; m_l = !m_raw;
                end else begin
                    m_h = m_raw && (m_run >= DEAD + 1 || m_side == 2);
                    m_l = !m_raw && (m_run >= DEAD + 1 || m_side == 1);
                end
                if (m_h) m_side = 2;
                if (m_l) m_side = 1;
                nr = (m_cnt < m_act);
                m_run = (nr == m_raw) ? ((m_run < 10000) ? m_run + 1 : m_run) : 1;
                m_raw = nr;
                cl = clamp($signed(duty_i));
                if (m_cnt == PERIOD - 1) begin
                    m_act  = duty_vld_i ? cl : m_sh;
                    m_load = 1'b1;
                end else begin
                    m_load = 1'b0;
                end
                if (duty_vld_i) m_sh = cl;
                m_cnt = (m_cnt + 1) % PERIOD;
                m_ps = (m_cnt == 0);
                m_since = (n > 1000) ? 1000 : n;
            end
        end
    end

    // Every-cycle comparison against the reference.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("pwm_h", {31'd0, pwm_h_o}, {31'd0, m_h});
                chk("pwm_l", {31'd0, pwm_l_o}, {31'd0, m_l});
                chk("period_start", {31'd0, period_start_o}, {31'd0, m_ps});
                chk("duty_load", {31'd0, duty_load_o}, {31'd0, m_load});
                chk("duty_act", {16'd0, duty_act_o}, 32'(m_act));
                chk("overlap", {31'd0, pwm_h_o & pwm_l_o}, 32'd0);
            end
        end
    end

    task automatic strobe(input int v);
        duty_i = 32'(v);
        duty_vld_i = 1'b1;
        @(negedge clk);
        duty_vld_i = 1'b0;
    endtask

    task automatic wait_cnt(input int x);
        bit found = 1'b0;
        for (int i = 0; i < 2 * PERIOD && !found; i++) begin
            if (m_cnt == x) found = 1'b1;
            else @(negedge clk);
        end
        chk("wait_cnt", {31'd0, found}, 32'd1);
    endtask

    task automatic wait_load();
        bit found = 1'b0;
        @(negedge clk);
        for (int i = 0; i < PERIOD + 5 && !found; i++) begin
            if (duty_load_o === 1'b1) found = 1'b1;
            else @(negedge clk);
        end
        chk("wait_load", {31'd0, found}, 32'd1);
    endtask

    // Count H, L and both-off cycles over one full period starting at a period_start.
    task automatic measure(input string nm, input int eh, input int el, input int ez);
        int ch = 0, cl = 0, cz = 0;
        bit found = 1'b0;
        @(negedge clk);
        for (int i = 0; i < PERIOD + 5 && !found; i++) begin
            if (period_start_o === 1'b1) found = 1'b1;
            else @(negedge clk);
        end
        chk({nm, "_sync"}, {31'd0, found}, 32'd1);
        for (int i = 0; i < PERIOD; i++) begin
            if (pwm_h_o === 1'b1) ch++;
            if (pwm_l_o === 1'b1) cl++;
            if (pwm_h_o === 1'b0 && pwm_l_o === 1'b0) cz++;
            @(negedge clk);
        end
        chk({nm, "_h_cycles"}, 32'(ch), 32'(eh));
        chk({nm, "_l_cycles"}, 32'(cl), 32'(el));
        chk({nm, "_off_cycles"}, 32'(cz), 32'(ez));
    endtask

    // SAFE window after reset release: zeros for DEAD cycles, then low side on.
    task automatic check_safe(input string nm);
        for (int k = 0; k < DEAD; k++) begin
            chk({nm, "_safe_h"}, {31'd0, pwm_h_o}, 32'd0);
            chk({nm, "_safe_l"}, {31'd0, pwm_l_o}, 32'd0);
            @(negedge clk);
        end
        chk({nm, "_low_on"}, {31'd0, pwm_l_o}, 32'd1);
    endtask

    initial begin
        int ps_cnt, k, v;
        bit found;
        int tbl[15] = '{-5, 0, 1, 4, 5, 6, 30, 50, 94, 95, 96, 98, 99, 100, 101};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_safe("rst1");
        ps_cnt = 0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            @(negedge clk);
            if (period_start_o === 1'b1) ps_cnt++;
        end
        chk("ps_count_3_periods", 32'(ps_cnt), 32'd3);

        wait_cnt(30);
        strobe(40);
        chk("act_before_load", {16'd0, duty_act_o}, 32'd0);
        wait_load();
        chk("act_40", {16'd0, duty_act_o}, 32'd40);
        chk("ps_with_load", {31'd0, period_start_o}, 32'd1);
        measure("d40", 35, 55, 10);

        strobe(-350);
        wait_load();
        chk("act_neg_clamp", {16'd0, duty_act_o}, 32'd0);
        measure("dneg", 0, 100, 0);

        strobe(350);
        wait_load();
        chk("act_pos_clamp", {16'd0, duty_act_o}, 32'd100);
        measure("dfull", 100, 0, 0);

        strobe(3);
        wait_load();
        chk("act_3", {16'd0, duty_act_o}, 32'd3);
        measure("d3", 0, 97, 3);

        wait_cnt(10); strobe(10);
        wait_cnt(40); strobe(60);
        wait_cnt(70); strobe(25);
        wait_load();
        chk("last_strobe_wins", {16'd0, duty_act_o}, 32'd25);
        wait_cnt(50); strobe(80);
        wait_cnt(99); strobe(25);
        chk("bypass_load", {31'd0, duty_load_o}, 32'd1);
        chk("bypass_act", {16'd0, duty_act_o}, 32'd25);
        wait_load();
        chk("bypass_shadow", {16'd0, duty_act_o}, 32'd25);

        strobe(50);
        wait_load();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pwm_h_o === 1'b1) found = 1'b1;
            else @(negedge clk);
        end
        chk("reach_high", {31'd0, found}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_h_off", {31'd0, pwm_h_o}, 32'd0);
        chk("rst_l_off", {31'd0, pwm_l_o}, 32'd0);
        chk("rst_act", {16'd0, duty_act_o}, 32'd0);
        rst_n = 1'b1;
        check_safe("rst2");
        k = DEAD;
        while (period_start_o !== 1'b1 && k < 3 * PERIOD) begin
            @(negedge clk);
            k++;
        end
        chk("cnt_restart", 32'(k), 32'(PERIOD));

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end else if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0) v = tbl[$urandom_range(0, 14)];
                else v = int'($urandom_range(0, 160)) - 20;
                strobe(v);
            end else begin
                @(negedge clk);
            end
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "timeout");
    end

endmodule
